// File: rtl/packetizer_pq.sv
// Frames camera lines (D packets) and status/FIFO control bytes (C packets) into
// self-delimiting, checksummed packets with valid/ready output backpressure.
module packetizer_pq #(
  parameter int DW         = 8,
  parameter int LBUF_DEPTH = 16,
  parameter int CTRL_LEN   = 128,
  parameter int LINE_W     = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic          stop,
  input  logic [DW-1:0] cam_data,
  input  logic          cam_href,
  input  logic          cam_vsync,
  input  logic [7:0]    status,
  input  logic [7:0]    sfifo_data,
  input  logic          sfifo_rdy,
  output logic          sfifo_rd,
  output logic [8:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          overrun,
  output logic          line_drop,
  input  logic          ovr_clr,
  output logic [3:0]    dbg_state
);

  // Output handshake: a byte moves when out_valid & out_ready are both high at a
  // rising clk edge; while out_valid is high and out_ready low, out_data holds.

  localparam int AW = $clog2(LBUF_DEPTH);
  localparam logic [8:0] CLEN = 9'(CTRL_LEN);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE0, S_PRE1, S_TYPE, S_SEQ, S_LNH, S_LNL, S_DATA,
    S_CSTAT, S_CFIFO, S_PAD, S_CKSUM, S_TRAIL
  } state_t;

  state_t              state_q, state_d;
  logic                href_q, vsync_q, stop_q;
  logic                is_data_q, cap_q;
  logic [7:0]          seq_q;
  logic [LINE_W-1:0]   line_q, pkt_line_q;
  logic [7:0]          csum_q;
  logic [8:0]          pay_cnt_q;
  logic [AW:0]         wr_ptr_q, rd_ptr_q;
  logic [DW-1:0]       lbuf_q [LBUF_DEPTH];
  logic                overrun_q, line_drop_q;

  logic                href_rise, href_fall, vsync_rise, stop_rise, abort;
  logic                start_c, start_d, pop, wr_en, xfer;
  logic                lb_empty, lb_full;
  logic [DW-1:0]       head;
  logic [15:0]         line16;

  assign href_rise  = cam_href & ~href_q;
  assign href_fall  = ~cam_href & href_q;
  assign vsync_rise = cam_vsync & ~vsync_q;
  assign stop_rise  = stop & ~stop_q;
  // A trailer already on the wire is not restarted by a late stop.
  assign abort      = stop_rise & (state_q != S_IDLE) & (state_q != S_TRAIL);

  assign lb_empty = (wr_ptr_q == rd_ptr_q);
  assign lb_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head     = lbuf_q[rd_ptr_q[AW-1:0]];
  assign line16   = 16'(pkt_line_q);
  assign wr_en    = (start_d | (cap_q & cam_href)) & ~abort & ~rst;
  assign xfer     = out_valid & out_ready;

  assign busy      = (state_q != S_IDLE);
  assign overrun   = overrun_q;
  assign line_drop = line_drop_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_data  = 9'h000;
    sfifo_rd  = 1'b0;
    start_c   = 1'b0;
    start_d   = 1'b0;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go && vsync_rise && !stop_rise) begin
          start_c = 1'b1;
          state_d = S_PRE0;
        end else if (go && href_rise && !stop_rise) begin
          start_d = 1'b1;
          state_d = S_PRE0;
        end
      end
      S_PRE0: begin
        out_valid = 1'b1;
        out_data  = 9'h10D;
        if (out_ready) state_d = S_PRE1;
      end
      S_PRE1: begin
        out_valid = 1'b1;
        out_data  = 9'h10A;
        if (out_ready) state_d = S_TYPE;
      end
      S_TYPE: begin
        out_valid = 1'b1;
        out_data  = is_data_q ? 9'h1FF : 9'h100;
        if (out_ready) state_d = S_SEQ;
      end
      S_SEQ: begin
        out_valid = 1'b1;
        out_data  = {1'b1, seq_q};
        if (out_ready) state_d = is_data_q ? S_LNH : S_CSTAT;
      end
      S_LNH: begin
        out_valid = 1'b1;
        out_data  = {1'b1, line16[15:8]};
        if (out_ready) state_d = S_LNL;
      end
      S_LNL: begin
        out_valid = 1'b1;
        out_data  = {1'b1, line16[7:0]};
        if (out_ready) state_d = S_DATA;
      end
      S_DATA: begin
        out_valid = ~lb_empty;
        out_data  = lb_empty ? 9'h000 : {1'b1, 8'(head)};
        pop       = ~lb_empty & out_ready;
        // Line is finished once capture has stopped and the buffer is drained.
        if (lb_empty && !cap_q) state_d = S_CKSUM;
      end
      S_CSTAT: begin
        out_valid = 1'b1;
        out_data  = {1'b1, status};
        if (out_ready) state_d = S_CFIFO;
      end
      S_CFIFO: begin
        if (sfifo_rdy && (pay_cnt_q < CLEN)) begin
          out_valid = 1'b1;
          out_data  = {1'b1, sfifo_data};
          sfifo_rd  = out_ready;
          if (out_ready && (pay_cnt_q == CLEN - 9'd1)) state_d = S_CKSUM;
        end else begin
          state_d = (pay_cnt_q < CLEN) ? S_PAD : S_CKSUM;
        end
      end
      S_PAD: begin
        if (pay_cnt_q < CLEN) begin
          out_valid = 1'b1;
          out_data  = 9'h100;
          if (out_ready && (pay_cnt_q == CLEN - 9'd1)) state_d = S_CKSUM;
        end else begin
          state_d = S_CKSUM;
        end
      end
      S_CKSUM: begin
        out_valid = 1'b1;
        out_data  = {1'b1, csum_q};
        if (out_ready) state_d = S_TRAIL;
      end
      S_TRAIL: begin
        out_valid = 1'b1;
        out_data  = 9'h000;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_TRAIL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      href_q      <= 1'b0;
      vsync_q     <= 1'b0;
      stop_q      <= 1'b0;
      is_data_q   <= 1'b0;
      cap_q       <= 1'b0;
      seq_q       <= 8'h00;
      line_q      <= '0;
      pkt_line_q  <= '0;
      csum_q      <= 8'h00;
      pay_cnt_q   <= 9'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overrun_q   <= 1'b0;
      line_drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      href_q  <= cam_href;
      vsync_q <= cam_vsync;
      stop_q  <= stop;

      if (state_q == S_TRAIL && xfer) seq_q <= seq_q + 8'd1;

      if (vsync_rise)     line_q <= '0;
      else if (href_fall) line_q <= line_q + 1'b1;

      if (start_d) begin
        pkt_line_q <= line_q;
        is_data_q  <= 1'b1;
      end else if (start_c) begin
        is_data_q  <= 1'b0;
      end

      if (abort)         cap_q <= 1'b0;
      else if (start_d)  cap_q <= 1'b1;
      else if (!cam_href) cap_q <= 1'b0;

      if (state_q == S_IDLE) begin
        csum_q <= 8'h00;
      end else if (xfer && (state_q inside {S_TYPE, S_SEQ, S_LNH, S_LNL, S_DATA,
                                            S_CSTAT, S_CFIFO, S_PAD})) begin
        csum_q <= csum_q + out_data[7:0];
      end

      if (state_q == S_IDLE) begin
        pay_cnt_q <= 9'd0;
      end else if (xfer && (state_q inside {S_CSTAT, S_CFIFO, S_PAD})) begin
        pay_cnt_q <= pay_cnt_q + 9'd1;
      end

      if (abort) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_en && !lb_full) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)               rd_ptr_q <= rd_ptr_q + 1'b1;
      end

      // A drop in the same cycle as a clear keeps the flag set.
      if (wr_en && lb_full) overrun_q <= 1'b1;
      else if (ovr_clr)     overrun_q <= 1'b0;

      line_drop_q <= href_rise & ~start_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !lb_full) lbuf_q[wr_ptr_q[AW-1:0]] <= cam_data;
  end

endmodule

// File: tb/tb_packetizer_pq.sv
// Directed bench for packetizer_pq: C/D packets, backpressure overrun, stop abort,
// simultaneous vsync/href, sequence wrap and mid-packet reset.
module tb_packetizer_pq;
  logic       clk = 1'b0;
  logic       rst, go, stop, cam_href, cam_vsync, out_ready, ovr_clr;
  logic [7:0] cam_data, status, sfifo_data;
  logic       sfifo_rdy, sfifo_rd, out_valid, busy, overrun, line_drop;
  logic [8:0] out_data;
  logic [3:0] dbg_state;

  int tests = 0;
  int fails = 0;
  int sf_idx = 0;
  int sf_n = 0;
  int trail_cnt = 0;
  int ld_cnt = 0;
  int ld0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  packetizer_pq dut (
    .clk(clk), .rst(rst), .go(go), .stop(stop),
    .cam_data(cam_data), .cam_href(cam_href), .cam_vsync(cam_vsync),
    .status(status), .sfifo_data(sfifo_data), .sfifo_rdy(sfifo_rdy),
    .sfifo_rd(sfifo_rd), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .overrun(overrun),
    .line_drop(line_drop), .ovr_clr(ovr_clr), .dbg_state(dbg_state)
  );

  // Show-ahead status FIFO model: entry k holds 8'h10 + k.
  assign sfifo_rdy  = (sf_n > sf_idx);
  assign sfifo_data = sfifo_rdy ? 8'(sf_idx + 16) : 8'h00;
  always @(posedge clk) if (sfifo_rd) sf_idx <= sf_idx + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        if (!out_data[8]) trail_cnt++;
      end
      if (line_drop) ld_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_trail(input string tag, input int budget);
    int start;
    int n;
    start = trail_cnt;
    n = 0;
    while (trail_cnt == start && n < budget) begin
      tick();
      n++;
    end
    chk(tag, trail_cnt - start, 1);
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    int n;
    int ok;
    logic [7:0] sum;

    rst = 1; go = 0; stop = 0; cam_data = 0; cam_href = 0; cam_vsync = 0;
    status = 8'h5A; out_ready = 1; ovr_clr = 0;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sfifo_rd", sfifo_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_line_drop", line_drop, 0);
    chk("rst_out_data", out_data, 9'h000);
    chk("rst_state", dbg_state, 4'd0);
    rst = 0; go = 1;
    tick();

    // T1: control packet, 3 FIFO bytes then zero pad to 128 payload bytes
    got_q.delete(); sf_n = 3;
    cam_vsync = 1; tick();
    wait_trail("t1_done", 400);
    cam_vsync = 0;
    exp_q = {9'h10D, 9'h10A, 9'h100, 9'h100, 9'h15A, 9'h110, 9'h111, 9'h112};
    repeat (124) exp_q.push_back(9'h100);
    exp_q.push_back(9'h18D);
    exp_q.push_back(9'h000);
    chk_stream("t1");
    chk("t1_sfifo_pops", sf_idx, 3);
    chk("t1_busy_after", busy, 0);

    // T2: five dropped lines with go=0, then line 5 with bytes 01..14
    go = 0;
    cam_vsync = 1; tick(); cam_vsync = 0; tick();
    ld0 = ld_cnt;
    repeat (5) begin
      cam_href = 1; tick(); tick();
      cam_href = 0; tick(); tick();
    end
    chk("t2_drops_go0", ld_cnt - ld0, 5);
    chk("t2_idle_go0", busy, 0);
    go = 1; tick();
    ld0 = ld_cnt; got_q.delete();
    for (int i = 1; i <= 20; i++) begin
      cam_href = 1; cam_data = 8'(i); tick();
    end
    cam_href = 0; cam_data = 0;
    wait_trail("t2_done", 100);
    exp_q = {9'h10D, 9'h10A, 9'h1FF, 9'h101, 9'h100, 9'h105};
    for (int i = 1; i <= 20; i++) exp_q.push_back(9'h100 + 9'(i));
    exp_q.push_back(9'h1D7);
    exp_q.push_back(9'h000);
    chk_stream("t2");
    chk("t2_no_drop", ld_cnt - ld0, 0);
    chk("t2_overrun", overrun, 0);

    // T3: 40-byte line 6, out_ready low for the first 24 cycles
    got_q.delete();
    for (int i = 1; i <= 40; i++) begin
      cam_href = 1; cam_data = 8'(i); out_ready = (i > 24); tick();
    end
    cam_href = 0; cam_data = 0; out_ready = 1;
    wait_trail("t3_done", 200);
    exp_q = {9'h10D, 9'h10A, 9'h1FF, 9'h102, 9'h100, 9'h106};
    for (int i = 0; i < 6 && i < got_q.size(); i++)
      chk($sformatf("t3_hdr[%0d]", i), got_q[i], exp_q[i]);
    n = got_q.size() - 8;
    chk("t3_some_dropped", (n >= 16 && n < 40), 1);
    ok = 1;
    sum = 8'hFF + 8'h02 + 8'h00 + 8'h06;
    for (int j = 0; j < n; j++) begin
      sum = sum + got_q[6+j][7:0];
      if (!got_q[6+j][8]) ok = 0;
      if (j > 0 && got_q[6+j][7:0] <= got_q[5+j][7:0]) ok = 0;
    end
    chk("t3_order", ok, 1);
    for (int j = 0; j < 16 && j < n; j++)
      chk($sformatf("t3_first[%0d]", j), got_q[6+j], 9'h101 + 9'(j));
    if (n > 0) chk("t3_last_byte", got_q[5+n], 9'h128);
    if (got_q.size() >= 2) begin
      chk("t3_cksum", got_q[got_q.size()-2], {1'b1, sum});
      chk("t3_trailer", got_q[got_q.size()-1], 9'h000);
    end
    chk("t3_overrun", overrun, 1);
    ovr_clr = 1; tick(); ovr_clr = 0;
    chk("t3_overrun_clr", overrun, 0);

    // T4: stop rise during DATA of line 7
    got_q.delete();
    for (int i = 1; i <= 20; i++) begin
      cam_href = 1; cam_data = 8'(i); stop = (i >= 12); tick();
      if (i == 12) begin
        chk("t4_trail_valid", out_valid, 1);
        chk("t4_trail_data", out_data, 9'h000);
      end
      if (i == 13) chk("t4_idle", busy, 0);
    end
    cam_href = 0; cam_data = 0; stop = 0;
    tick(); tick();
    exp_q = {9'h10D, 9'h10A, 9'h1FF, 9'h103, 9'h100, 9'h107,
             9'h101, 9'h102, 9'h103, 9'h104, 9'h105, 9'h000};
    chk_stream("t4");

    // T5: vsync and href rise together -> control packet, line dropped, seq 4
    got_q.delete(); ld0 = ld_cnt;
    cam_vsync = 1; cam_href = 1; tick();
    cam_href = 0; tick();
    wait_trail("t5_done", 400);
    cam_vsync = 0; tick();
    chk("t5_line_drop", ld_cnt - ld0, 1);
    chk("t5_len", got_q.size(), 134);
    if (got_q.size() == 134) begin
      chk("t5_type", got_q[2], 9'h100);
      chk("t5_seq", got_q[3], 9'h104);
      chk("t5_status", got_q[4], 9'h15A);
      chk("t5_pad", got_q[5], 9'h100);
      chk("t5_cksum", got_q[132], 9'h15E);
      chk("t5_trailer", got_q[133], 9'h000);
    end

    // Sequence numbers 5..255, then the wrapped packet carries seq 0 (line 252)
    for (int k = 0; k < 251; k++) begin
      cam_href = 1; cam_data = 8'(k); tick();
      cam_href = 0; tick();
      wait_trail("wrap_pkt", 40);
    end
    got_q.delete();
    cam_href = 1; cam_data = 8'hAA; tick();
    cam_href = 0; tick();
    wait_trail("wrap_done", 40);
    exp_q = {9'h10D, 9'h10A, 9'h1FF, 9'h100, 9'h100, 9'h1FC, 9'h1AA, 9'h1A5, 9'h000};
    chk_stream("wrap");

    // T6: reset in the middle of a control packet (seq 1)
    got_q.delete(); sf_n = sf_idx + 50;
    cam_vsync = 1; tick(); cam_vsync = 0;
    repeat (9) tick();
    chk("t6_seq_before", (got_q.size() > 3) ? got_q[3] : 9'h0FF, 9'h101);
    chk("t6_sfifo_rd_active", sfifo_rd, 1);
    chk("t6_busy_before", busy, 1);
    rst = 1; tick();
    chk("t6_out_valid", out_valid, 0);
    chk("t6_sfifo_rd", sfifo_rd, 0);
    chk("t6_busy", busy, 0);
    chk("t6_out_data", out_data, 9'h000);
    rst = 0; tick();
    got_q.delete();
    cam_href = 1; cam_data = 8'h3C; tick();
    cam_href = 0; tick();
    wait_trail("t6_after_done", 40);
    exp_q = {9'h10D, 9'h10A, 9'h1FF, 9'h100, 9'h100, 9'h100, 9'h13C, 9'h13B, 9'h000};
    chk_stream("t6_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
